// File: rtl/matrix_scan.sv
// Double-buffered LED matrix scanner: rows are blanked then driven one at a time,
// and a committed back-buffer image is copied to the front buffer only at a frame boundary.

module matrix_scan_row #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             we_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             swap_i,
    output logic [WIDTH-1:0] front_o
);
    logic [WIDTH-1:0] back_q;
    logic [WIDTH-1:0] front_q;

    // front takes the pre-edge back word, so a write on the swap edge lands in back only
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            back_q  <= '0;
            front_q <= '0;
        end else begin
            if (we_i)
                back_q <= wdata_i;
            if (swap_i)
                front_q <= back_q;
        end
    end

    assign front_o = front_q;
endmodule

module matrix_scan #(
    parameter int WIDTH   = 8,
    parameter int REGBITS = 3,
    parameter int DWELL   = 1000,
    parameter int BLANK   = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               wr_en,
    input  logic [REGBITS-1:0] wr_addr,
    input  logic [WIDTH-1:0]   wr_data,
    input  logic               gen_done,
    output logic [WIDTH-1:0]   row,
    output logic [WIDTH-1:0]   col,
    output logic               frame_start,
    output logic               swap_pending
);
    typedef enum logic {
        S_BLANK = 1'b0,
        S_DRIVE = 1'b1
    } state_e;

    localparam logic [15:0]        BLANK_M1 = 16'(BLANK - 1);
    localparam logic [15:0]        DWELL_M1 = 16'(DWELL - 1);
    localparam logic [REGBITS-1:0] RIDX_MAX = REGBITS'(WIDTH - 1);

    state_e                         state_q, state_d;
    logic [REGBITS-1:0]             ridx_q, ridx_d;
    logic [15:0]                    cnt_q, cnt_d;
    logic [WIDTH-1:0]               row_q, row_d;
    logic [WIDTH-1:0]               col_q, col_d;
    logic                           fs_q;
    logic                           sp_q, sp_d;
    logic                           wrap;
    logic                           swap;
    logic [WIDTH-1:0][WIDTH-1:0]    front;

    for (genvar g = 0; g < WIDTH; g++) begin : g_row
        matrix_scan_row #(.WIDTH(WIDTH)) u_row (
            .clk_i   (clk),
            .rst_ni  (reset),
            .we_i    (wr_en && (wr_addr == REGBITS'(g))),
            .wdata_i (wr_data),
            .swap_i  (swap),
            .front_o (front[g])
        );
    end

    always_comb begin
        state_d = state_q;
        ridx_d  = ridx_q;
        cnt_d   = cnt_q + 16'd1;
        wrap    = 1'b0;
        case (state_q)
            S_BLANK: begin
                if (cnt_q == BLANK_M1) begin
                    state_d = S_DRIVE;
                    cnt_d   = '0;
                end
            end
            S_DRIVE: begin
                if (cnt_q == DWELL_M1) begin
                    state_d = S_BLANK;
                    cnt_d   = '0;
                    wrap    = (ridx_q == RIDX_MAX);
                    ridx_d  = wrap ? '0 : ridx_q + REGBITS'(1);
                end
            end
            default: ;
        endcase

        // a gen_done arriving on the wrap cycle itself swaps without waiting a frame
        swap = wrap && (sp_q || gen_done);
        sp_d = (sp_q || gen_done) && !swap;

        // outputs are computed from the next state so the registers line up with it;
        // front never changes on an edge that enters DRIVE, so front is safe to read here
        row_d = '0;
        col_d = '1;
        if (state_d == S_DRIVE) begin
            row_d[ridx_d] = 1'b1;
            col_d         = ~front[ridx_d];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_BLANK;
            ridx_q  <= '0;
            cnt_q   <= '0;
            row_q   <= '0;
            col_q   <= '1;
            fs_q    <= 1'b0;
            sp_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            ridx_q  <= ridx_d;
            cnt_q   <= cnt_d;
            row_q   <= row_d;
            col_q   <= col_d;
            fs_q    <= swap;
            sp_q    <= sp_d;
        end
    end

    assign row          = row_q;
    assign col          = col_q;
    assign frame_start  = fs_q;
    assign swap_pending = sp_q;
endmodule

// File: tb/tb_matrix_scan.sv
// Directed bench for matrix_scan at WIDTH=8, DWELL=4, BLANK=2 (row period 6, frame 48).

module tb_matrix_scan;
    localparam int W     = 8;
    localparam int RB    = 3;
    localparam int DW    = 4;
    localparam int BL    = 2;
    localparam int ROWP  = BL + DW;
    localparam int FRMP  = W * ROWP;

    logic          clk      = 1'b0;
    logic          reset    = 1'b0;
    logic          wr_en    = 1'b0;
    logic [RB-1:0] wr_addr  = '0;
    logic [W-1:0]  wr_data  = '0;
    logic          gen_done = 1'b0;
    logic [W-1:0]  row;
    logic [W-1:0]  col;
    logic          frame_start;
    logic          swap_pending;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    logic [W-1:0] ef [W];

    always #5 clk = ~clk;

    matrix_scan #(.WIDTH(W), .REGBITS(RB), .DWELL(DW), .BLANK(BL)) dut (
        .clk          (clk),
        .reset        (reset),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .gen_done     (gen_done),
        .row          (row),
        .col          (col),
        .frame_start  (frame_start),
        .swap_pending (swap_pending)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // hand-directed expectations: which cycles hold a pending swap, pulse frame_start,
    // and when the displayed image picks up each committed row
    task automatic check_cycle(input int ph);
        int p, r, o;
        logic [W-1:0] er, ec;
        logic esp, efs;
        p = cyc % FRMP;
        r = p / ROWP;
        o = p % ROWP;
        if (ph == 1) begin
            if (cyc == 48)  ef[3] = 8'hA5;
            if (cyc == 96)  ef[0] = 8'h3C;
            if (cyc == 144) ef[0] = 8'hFF;
            esp = (cyc >= 13 && cyc <= 47) || (cyc >= 101 && cyc <= 143) || (cyc >= 211);
            efs = (cyc == 48) || (cyc == 96) || (cyc == 144);
        end else begin
            esp = (cyc >= 51 && cyc <= 95);
            efs = (cyc == 96);
        end
        er = '0;
        ec = '1;
        if (o >= BL) begin
            er[r] = 1'b1;
            ec    = ~ef[r];
        end
        chk("row", 32'(row), 32'(er));
        chk("col", 32'(col), 32'(ec));
        chk("swap_pending", 32'(swap_pending), 32'(esp));
        chk("frame_start", 32'(frame_start), 32'(efs));
    endtask

    task automatic drive_cycle(input int ph);
        wr_en    = 1'b0;
        gen_done = 1'b0;
        if (ph == 1) begin
            case (cyc)
                10:  begin wr_en = 1'b1; wr_addr = 3'd3; wr_data = 8'hA5; end
                12:  gen_done = 1'b1;
                30:  gen_done = 1'b1;
                60:  begin wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'h3C; end
                95:  begin gen_done = 1'b1; wr_en = 1'b1; wr_addr = 3'd0; wr_data = 8'hFF; end
                100: gen_done = 1'b1;
                210: gen_done = 1'b1;
                default: ;
            endcase
        end else begin
            if (cyc == 50) gen_done = 1'b1;
        end
    endtask

    task automatic run(input int ph, input int n);
        for (int c = 0; c < n; c++) begin
            cyc = c;
            if (c > 0) @(negedge clk);
            check_cycle(ph);
            drive_cycle(ph);
        end
    endtask

    initial begin
        for (int i = 0; i < W; i++) ef[i] = '0;
        repeat (2) @(negedge clk);
        chk("rst_row", 32'(row), 32'h00);
        chk("rst_col", 32'(col), 32'hFF);
        chk("rst_sp", 32'(swap_pending), 32'h0);
        chk("rst_fs", 32'(frame_start), 32'h0);

        reset = 1'b1;
        run(1, 220);

        // cycle 219 shows row 4; reset must blank the matrix before the next edge
        reset = 1'b0;
        #1;
        chk("arst_row", 32'(row), 32'h00);
        chk("arst_col", 32'(col), 32'hFF);
        chk("arst_sp", 32'(swap_pending), 32'h0);
        chk("arst_fs", 32'(frame_start), 32'h0);

        for (int i = 0; i < W; i++) ef[i] = '0;
        wr_en    = 1'b0;
        gen_done = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        run(2, 106);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout cyc=%0d", cyc);
        $fatal(1);
    end
endmodule
